// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch PC controller.
// Imported by pc_fetch_ctrl and pc_redirect_buf.
package pc_fetch_ctrl_pkg;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic RstEnable   = 1'b1;
  localparam logic NoStop      = 1'b0;
  localparam logic Stop        = 1'b1;
  localparam logic Branch      = 1'b1;
  localparam logic NotBranch   = 1'b0;

  localparam int unsigned DEFAULT_ADDR_W    = 32;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry holding register for a branch redirect that arrived while the PC
// could not advance. Clear beats capture, capture beats consume.
module pc_redirect_buf
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              consume,
  input  logic              clear,
  input  logic [ADDR_W-1:0] target_in,
  output logic              valid,
  output logic [ADDR_W-1:0] target
);

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking = here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the target word is qualified by valid, so it needs no reset;
  // leaving data registers unreset keeps reset fan-out to control bits only.
  always_ff @(posedge clk) begin
    if (capture && !clear) begin
      target <= target_in;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-address generator: PC state machine, next-PC priority mux, imem
// req/gnt handshake and registered (fetch_pc, valid) pair for IF/ID.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEFAULT_RESET_VEC),
  parameter int unsigned       STEP       = 4,
  parameter int unsigned       ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              imem_gnt_i,
  output logic              ce_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] fetch_pc_o,
  output logic              fetch_valid_o,
  output logic              misalign_o
);

  localparam logic [ADDR_W-1:0] STEP_EXT = ADDR_W'(STEP);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic              fetch_valid_q;
  logic              adv;
  logic              live_branch;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_target;

  assign live_branch = (branch_flag_i == Branch);
  assign imem_req_o  = ce_o & (stall_i == NoStop) & ~flush_i;
  assign adv         = imem_req_o & imem_gnt_i;

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk       (clk),
    .rst       (rst),
    .capture   (live_branch & ~adv & ~flush_i & (state_q == ST_RUN)),
    .consume   (adv),
    .clear     (flush_i & (state_q == ST_RUN)),
    .target_in (branch_target_i),
    .valid     (buf_valid),
    .target    (buf_target)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q       <= ST_OFF;
      pc_q          <= RESET_VEC;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= adv;
      if (adv) begin
        fetch_pc_q <= pc_q;
      end
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ce_o    = ChipDisable;
    pc_d    = pc_q;
    unique case (state_q)
      ST_OFF: begin
        state_d = ST_RUN;
        pc_d    = RESET_VEC;
      end
      ST_RUN: begin
        ce_o = ChipEnable;
        // Flush outranks stall and grant; a live branch outranks a buffered one.
        if (flush_i) begin
          pc_d = flush_pc_i;
        end else if (adv && live_branch) begin
          pc_d = branch_target_i;
        end else if (adv && buf_valid) begin
          pc_d = buf_target;
        end else if (adv) begin
          pc_d = pc_q + STEP_EXT;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  assign pc_o          = pc_q;
  assign fetch_pc_o    = fetch_pc_q;
  assign fetch_valid_o = fetch_valid_q;

  generate
    if (ALIGN_BITS == 0) begin : g_no_align
      assign misalign_o = 1'b0;
    end else begin : g_align
      assign misalign_o = |pc_q[ALIGN_BITS-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a table of per-cycle vectors through
// a scoreboard queue, then a stall/grant sequence checked against a PC model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] B = 32'hBFC0_0000;

  typedef struct {
    logic        rst, stall, flush;
    logic [31:0] flush_pc;
    logic        br;
    logic [31:0] tgt;
    logic        gnt;
    logic        req, ce;
    logic [31:0] pc, fpc;
    logic        fv, mis;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, br = 1'b0, gnt = 1'b1;
  logic [31:0] flush_pc = '0, tgt = '0;
  logic        ce, req, fv, mis;
  logic [31:0] pc, fpc;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  pc_fetch_ctrl #(
    .ADDR_W     (32),
    .RESET_VEC  (B),
    .STEP       (4),
    .ALIGN_BITS (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall),
    .flush_i         (flush),
    .flush_pc_i      (flush_pc),
    .branch_flag_i   (br),
    .branch_target_i (tgt),
    .imem_gnt_i      (gnt),
    .ce_o            (ce),
    .imem_req_o      (req),
    .pc_o            (pc),
    .fetch_pc_o      (fpc),
    .fetch_valid_o   (fv),
    .misalign_o      (mis)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int r, int s, int f, logic [31:0] fp, int b, logic [31:0] t,
                              int g, int rq, int c, logic [31:0] p, logic [31:0] fp2,
                              int v, int m);
    vec_t x;
    x.rst = (r != 0); x.stall = (s != 0); x.flush = (f != 0); x.flush_pc = fp;
    x.br = (b != 0); x.tgt = t; x.gnt = (g != 0);
    x.req = (rq != 0); x.ce = (c != 0); x.pc = p; x.fpc = fp2;
    x.fv = (v != 0); x.mis = (m != 0);
    return x;
  endfunction

  // Drive one cycle of inputs, check the combinational request before the
  // edge, then pop the expectation and check registered outputs after it.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    rst = v.rst; stall = v.stall; flush = v.flush; flush_pc = v.flush_pc;
    br = v.br; tgt = v.tgt; gnt = v.gnt;
    exp_q.push_back(v);
    #1;
    check($sformatf("%s req", tag), {31'b0, req}, {31'b0, v.req});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("%s ce", tag), {31'b0, ce}, {31'b0, e.ce});
    check($sformatf("%s pc", tag), pc, e.pc);
    check($sformatf("%s fetch_pc", tag), fpc, e.fpc);
    check($sformatf("%s fetch_valid", tag), {31'b0, fv}, {31'b0, e.fv});
    check($sformatf("%s misalign", tag), {31'b0, mis}, {31'b0, e.mis});
  endtask

  initial begin
    logic [31:0] mpc, mfpc;
    repeat (2) @(posedge clk);

    //            rst st fl flush_pc     br tgt    gnt req ce pc             fpc            fv mis
    tbl.push_back(mk(1, 0, 0, 'h0,         0, 'h0,   1,  0, 0, B,             'h0,           0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  0, 1, B,             'h0,           0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, B + 4,         B,             1, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, B + 8,         B + 4,         1, 0));
    tbl.push_back(mk(0, 0, 1, 'h10,        0, 'h0,   1,  0, 1, 'h10,          B + 4,         0, 0));
    tbl.push_back(mk(0, 1, 0, 'h0,         0, 'h0,   1,  0, 1, 'h10,          B + 4,         0, 0));
    tbl.push_back(mk(0, 1, 0, 'h0,         0, 'h0,   1,  0, 1, 'h10,          B + 4,         0, 0));
    tbl.push_back(mk(0, 1, 0, 'h0,         0, 'h0,   1,  0, 1, 'h10,          B + 4,         0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, 'h14,          'h10,          1, 0));
    tbl.push_back(mk(0, 0, 1, 'h40,        0, 'h0,   1,  0, 1, 'h40,          'h10,          0, 0));
    tbl.push_back(mk(0, 1, 0, 'h0,         1, 'h200, 1,  0, 1, 'h40,          'h10,          0, 0));
    tbl.push_back(mk(0, 1, 0, 'h0,         0, 'h0,   1,  0, 1, 'h40,          'h10,          0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, 'h200,         'h40,          1, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, 'h204,         'h200,         1, 0));
    tbl.push_back(mk(0, 1, 0, 'h0,         1, 'h300, 1,  0, 1, 'h204,         'h200,         0, 0));
    tbl.push_back(mk(0, 1, 1, 'h180,       0, 'h0,   1,  0, 1, 'h180,         'h200,         0, 0));
    tbl.push_back(mk(0, 1, 0, 'h0,         0, 'h0,   1,  0, 1, 'h180,         'h200,         0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, 'h184,         'h180,         1, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, 'h188,         'h184,         1, 0));
    tbl.push_back(mk(0, 0, 1, 'h20,        0, 'h0,   1,  0, 1, 'h20,          'h184,         0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   0,  1, 1, 'h20,          'h184,         0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   0,  1, 1, 'h20,          'h184,         0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, 'h24,          'h20,          1, 0));
    tbl.push_back(mk(0, 0, 1, 'hFFFF_FFFC, 0, 'h0,   1,  0, 1, 'hFFFF_FFFC,   'h20,          0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, 'h0,           'hFFFF_FFFC,   1, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         1, 'h102, 1,  1, 1, 'h102,         'h0,           1, 1));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, 'h106,         'h102,         1, 1));
    tbl.push_back(mk(0, 0, 1, 'h40,        0, 'h0,   1,  0, 1, 'h40,          'h102,         0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         1, 'h500, 0,  1, 1, 'h40,          'h102,         0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         1, 'h600, 0,  1, 1, 'h40,          'h102,         0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, 'h600,         'h40,          1, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         1, 'h700, 0,  1, 1, 'h600,         'h40,          0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         1, 'h800, 1,  1, 1, 'h800,         'h600,         1, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, 'h804,         'h800,         1, 0));
    tbl.push_back(mk(0, 1, 0, 'h0,         1, 'h900, 1,  0, 1, 'h804,         'h800,         0, 0));
    tbl.push_back(mk(1, 1, 0, 'h0,         0, 'h0,   1,  0, 0, B,             'h0,           0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  0, 1, B,             'h0,           0, 0));
    tbl.push_back(mk(0, 0, 0, 'h0,         0, 'h0,   1,  1, 1, B + 4,         B,             1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("v%0d", i));
    end

    // Random stall/grant run against a sequential-PC model.
    mpc  = B + 4;
    mfpc = B;
    for (int i = 0; i < 40; i++) begin
      int s, g;
      vec_t v;
      s = ($urandom_range(0, 3) == 0) ? 1 : 0;
      g = $urandom_range(0, 1);
      if (s == 0 && g != 0) begin
        mfpc = mpc;
        mpc  = mpc + 4;
        v = mk(0, s, 0, 'h0, 0, 'h0, g, 1, 1, mpc, mfpc, 1, 0);
      end else begin
        v = mk(0, s, 0, 'h0, 0, 'h0, g, (s == 0) ? 1 : 0, 1, mpc, mfpc, 0, 0);
      end
      apply(v, $sformatf("r%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Parametrised successor to the single-channel PC register.
- Generates the instruction-fetch address for the IF stage and drives a req/gnt handshake to instruction memory.
- Supports a configurable reset vector and step, and an exception flush that overrides stall.
- Buffers a branch redirect that arrives while the PC cannot advance, and forwards a registered (fetch_pc, valid) pair to IF/ID.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- RESET_VEC, 32'h0000_0000, PC value held during reset and on the first enabled cycle.
- STEP, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low PC bits that must be zero; 0 disables the alignment check.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall_i  in  1  PC-stage stall from CTRL (stall[0]).
- flush_i  in  1  exception/eret redirect; highest priority.
- flush_pc_i  in  ADDR_W  flush target.
- branch_flag_i  in  1  branch taken from ID.
- branch_target_i  in  ADDR_W  branch target from ID.
- imem_gnt_i  in  1  instruction memory accepts the current request.
- ce_o  out  1  instruction memory chip enable.
- imem_req_o  out  1  fetch request.
- pc_o  out  ADDR_W  current fetch address; doubles as imem address.
- fetch_pc_o  out  ADDR_W  address of the last granted fetch.
- fetch_valid_o  out  1  fetch_pc_o is new this cycle.
- misalign_o  out  1  pc_o violates ALIGN_BITS.

Behaviour:
- Reset: rst=1 at an edge gives ce_o=0, pc_o=RESET_VEC, fetch_pc_o=0, fetch_valid_o=0, redirect buffer cleared, state OFF.
- State machine:
  - OFF: ce_o=0, imem_req_o=0, pc_o holds RESET_VEC. Next edge with rst=0 moves to RUN and sets ce_o=1.
  - RUN: ce_o=1. Reset from any state returns to OFF; reset mid-stall or mid-wait discards the buffered redirect.
- imem_req_o = ce_o & ~stall_i & ~flush_i (combinational).
- Advance condition: adv = imem_req_o & imem_gnt_i.
- Next-PC priority, evaluated each RUN edge:
  1. flush_i=1: pc_o <= flush_pc_i. Applies regardless of stall_i or gnt. Clears the redirect buffer. fetch_valid_o <= 0.
  2. adv & branch_flag_i: pc_o <= branch_target_i.
  3. adv & buffer valid: pc_o <= buffered target; buffer cleared.
  4. adv: pc_o <= pc_o + STEP, wrapping modulo 2^ADDR_W (all-ones region + STEP wraps to low addresses, no flag).
  5. Otherwise pc_o holds.
- Redirect buffer:
  - branch_flag_i=1 with adv=0 and flush_i=0 captures branch_target_i (valid=1).
  - A later branch while the buffer is valid overwrites it (last wins).
  - Branch and buffer both present at adv: the live branch wins and the buffer clears.
- Fetch output, registered: on adv, fetch_pc_o <= pc_o and fetch_valid_o <= 1. Otherwise fetch_valid_o <= 0 and fetch_pc_o holds. Latency is one cycle from grant.
- misalign_o: combinational from pc_o, high when pc_o[ALIGN_BITS-1:0] != 0. Informational only; it does not block the request. Tied to 0 when ALIGN_BITS=0.
- Widths: STEP is zero-extended to ADDR_W; no carry out is kept.

Decomposition:
- Shared package: ChipEnable/ChipDisable, RstEnable, NoStop/Stop, Branch/NotBranch constants, plus default ADDR_W and RESET_VEC.
- One natural sub-module, pc_redirect_buf: 1-entry valid+target register with capture/consume/clear inputs.
- Next-PC mux and state machine stay in the top level.

Test Plan:
- Reset release, RESET_VEC=32'hBFC0_0000, gnt tied 1:
  - ce_o rises 1 cycle after rst falls.
  - pc_o sequence BFC0_0000, BFC0_0004, BFC0_0008.
  - fetch_pc_o lags pc_o by one cycle with fetch_valid_o=1.
- stall_i=1 for 3 cycles at pc 0x10 → imem_req_o=0, pc_o holds 0x10, fetch_valid_o=0; on release pc_o → 0x14.
- branch_flag_i=1, target 0x200, pulsed during stall at pc 0x40 → buffer captures it; first adv after release gives pc_o=0x200, not 0x44.
- flush_i=1, flush_pc_i=0x180, during stall with buffered branch 0x300 → next edge pc_o=0x180, buffer cleared; after release sequence 0x184, 0x188 (no 0x300).
- gnt low 2 cycles at pc 0x20 → pc_o holds 0x20, fetch_valid_o=0; gnt high gives pc_o=0x24 and fetch_pc_o=0x20.
- Wrap and misalign: ADDR_W=32 at pc 0xFFFF_FFFC → next pc_o=0x0; branch to 0x102 → misalign_o=1 while pc_o=0x102.
